// File: rtl/mem_line_arbiter_if.sv
// Bus bundle for mem_line_arbiter: the I and D refill request/ack ports and the data RAM port.
// Handshake: req is held with stable payload until a one-cycle ack; rdata is valid in the ack cycle.
interface mem_line_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int LINE_W = 256
);
    logic              i_req;
    logic [ADDR_W-1:0] i_addr;
    logic              i_ack;
    logic [LINE_W-1:0] i_rdata;

    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [LINE_W-1:0] d_wdata;
    logic              d_ack;
    logic [LINE_W-1:0] d_rdata;

    logic              ram_read_op;
    logic              ram_write_op;
    logic [ADDR_W-1:0] ram_addr;
    logic [LINE_W-1:0] ram_data_o;
    logic [LINE_W-1:0] ram_data_i;

    modport slave (
        input  i_req, i_addr,
        output i_ack, i_rdata,
        input  d_req, d_we, d_addr, d_wdata,
        output d_ack, d_rdata,
        output ram_read_op, ram_write_op, ram_addr, ram_data_o,
        input  ram_data_i
    );

    modport master (
        output i_req, i_addr,
        input  i_ack, i_rdata,
        output d_req, d_we, d_addr, d_wdata,
        input  d_ack, d_rdata,
        input  ram_read_op, ram_write_op, ram_addr, ram_data_o,
        output ram_data_i
    );
endinterface

// File: rtl/mem_line_arbiter.sv
// Round-robin arbiter sharing one line-wide RAM port between I refill and D refill/writeback.
// Optional grant/wait statistics outputs are enabled with `define MEM_ARB_STATS_EN.
module mem_line_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int LINE_W  = 256,
    parameter int RAM_LAT = 2
) (
    input  logic                    CLK,
    input  logic                    RST,
    mem_line_arbiter_if.slave       bus,
    output logic [1:0]              dbg_state
`ifdef MEM_ARB_STATS_EN
    ,
    output logic [31:0]             stat_i_grants,
    output logic [31:0]             stat_d_grants,
    output logic [31:0]             stat_wait_cycles
`endif
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_RESP   = 2'd2
    } state_t;

    localparam logic [3:0] CNT_LOAD = 4'(RAM_LAT - 1);

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              last_d_q, last_d_d;   // 1: last grant went to D
    logic              win_d_q, win_d_d;     // 1: access in flight belongs to D
    logic              rd_op_q, rd_op_d;
    logic              wr_op_q, wr_op_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [LINE_W-1:0] wdata_q, wdata_d;
    logic              i_ack_q, i_ack_d;
    logic              d_ack_q, d_ack_d;
    logic [LINE_W-1:0] i_rdata_q, i_rdata_d;
    logic [LINE_W-1:0] d_rdata_q, d_rdata_d;

    logic grant_i, grant_d;

    // Contention goes to whoever did not win last; a lone requester always wins.
    assign grant_i = (state_q == S_IDLE) && bus.i_req && (!bus.d_req || last_d_q);
    assign grant_d = (state_q == S_IDLE) && bus.d_req && (!bus.i_req || !last_d_q);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        last_d_d  = last_d_q;
        win_d_d   = win_d_q;
        rd_op_d   = rd_op_q;
        wr_op_d   = wr_op_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        i_ack_d   = 1'b0;
        d_ack_d   = 1'b0;
        i_rdata_d = i_rdata_q;
        d_rdata_d = d_rdata_q;

        case (state_q)
            S_IDLE: begin
                if (grant_d) begin
                    addr_d   = bus.d_addr;
                    wdata_d  = bus.d_wdata;
                    rd_op_d  = !bus.d_we;
                    wr_op_d  = bus.d_we;
                    cnt_d    = CNT_LOAD;
                    last_d_d = 1'b1;
                    win_d_d  = 1'b1;
                    state_d  = S_ACCESS;
                end else if (grant_i) begin
                    addr_d   = bus.i_addr;
                    rd_op_d  = 1'b1;
                    wr_op_d  = 1'b0;
                    cnt_d    = CNT_LOAD;
                    last_d_d = 1'b0;
                    win_d_d  = 1'b0;
                    state_d  = S_ACCESS;
                end
            end
            S_ACCESS: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    if (rd_op_q) begin
                        if (win_d_q) d_rdata_d = bus.ram_data_i;
                        else         i_rdata_d = bus.ram_data_i;
                    end
                    rd_op_d = 1'b0;
                    wr_op_d = 1'b0;
                    d_ack_d = win_d_q;
                    i_ack_d = !win_d_q;
                    state_d = S_RESP;
                end
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

`ifdef MEM_ARB_STATS_EN
    logic [31:0] st_i_q, st_i_d;
    logic [31:0] st_d_q, st_d_d;
    logic [31:0] st_w_q, st_w_d;
    logic        wait_i, wait_d;

    // A requester is waiting unless it owns the access in flight or is being granted now.
    assign wait_i = bus.i_req && !grant_i && !((state_q != S_IDLE) && !win_d_q);
    assign wait_d = bus.d_req && !grant_d && !((state_q != S_IDLE) && win_d_q);

    always_comb begin
        st_i_d = st_i_q + {31'b0, grant_i};
        st_d_d = st_d_q + {31'b0, grant_d};
        st_w_d = st_w_q + {31'b0, (wait_i | wait_d)};
    end

    assign stat_i_grants    = st_i_q;
    assign stat_d_grants    = st_d_q;
    assign stat_wait_cycles = st_w_q;
`endif

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q   <= S_IDLE;
            cnt_q     <= 4'd0;
            last_d_q  <= 1'b0;
            win_d_q   <= 1'b0;
            rd_op_q   <= 1'b0;
            wr_op_q   <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            i_ack_q   <= 1'b0;
            d_ack_q   <= 1'b0;
            i_rdata_q <= '0;
            d_rdata_q <= '0;
`ifdef MEM_ARB_STATS_EN
            st_i_q    <= 32'd0;
            st_d_q    <= 32'd0;
            st_w_q    <= 32'd0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            last_d_q  <= last_d_d;
            win_d_q   <= win_d_d;
            rd_op_q   <= rd_op_d;
            wr_op_q   <= wr_op_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            i_ack_q   <= i_ack_d;
            d_ack_q   <= d_ack_d;
            i_rdata_q <= i_rdata_d;
            d_rdata_q <= d_rdata_d;
`ifdef MEM_ARB_STATS_EN
            st_i_q    <= st_i_d;
            st_d_q    <= st_d_d;
            st_w_q    <= st_w_d;
`endif
        end
    end

    assign bus.ram_read_op  = rd_op_q;
    assign bus.ram_write_op = wr_op_q;
    assign bus.ram_addr     = addr_q;
    assign bus.ram_data_o   = wdata_q;
    assign bus.i_ack        = i_ack_q;
    assign bus.d_ack        = d_ack_q;
    assign bus.i_rdata      = i_rdata_q;
    assign bus.d_rdata      = d_rdata_q;
    assign dbg_state        = state_q;

endmodule

// File: tb/tb_mem_line_arbiter.sv
// Directed bench for mem_line_arbiter with a small behavioural line RAM.
// Build with +define+MEM_ARB_STATS_EN to also check the statistics counters.
module tb_mem_line_arbiter;

    localparam int AW  = 32;
    localparam int LW  = 256;
    localparam int LAT = 2;

    typedef logic [LW-1:0] val_t;

    logic       CLK;
    logic       RST;
    logic [1:0] dbg_state;
`ifdef MEM_ARB_STATS_EN
    logic [31:0] stat_i_grants;
    logic [31:0] stat_d_grants;
    logic [31:0] stat_wait_cycles;
`endif

    int n_checks = 0;
    int n_errors = 0;

    mem_line_arbiter_if #(.ADDR_W(AW), .LINE_W(LW)) bus ();

    mem_line_arbiter #(.ADDR_W(AW), .LINE_W(LW), .RAM_LAT(LAT)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .bus       (bus),
        .dbg_state (dbg_state)
`ifdef MEM_ARB_STATS_EN
        ,
        .stat_i_grants    (stat_i_grants),
        .stat_d_grants    (stat_d_grants),
        .stat_wait_cycles (stat_wait_cycles)
`endif
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic val_t line_of(input logic [7:0] idx);
        return {8{24'hC0DE00, idx}};
    endfunction

    // Line RAM: writes on every edge with the write strobe, read data registered from the read strobe.
    val_t mem [256];
    always @(posedge CLK) begin
        if (RST) begin
            for (int k = 0; k < 256; k++) mem[k] <= line_of(8'(k));
            bus.ram_data_i <= '0;
        end else begin
            if (bus.ram_write_op) mem[bus.ram_addr[7:0]] <= bus.ram_data_o;
            if (bus.ram_read_op)  bus.ram_data_i <= mem[bus.ram_addr[7:0]];
        end
    end

    task automatic check(input string tag, input val_t obs, input val_t exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic do_i_read(input logic [AW-1:0] addr, input val_t exp_rd);
        bus.i_req  = 1'b1;
        bus.i_addr = addr;
        for (int k = 0; k < LAT; k++) begin
            @(negedge CLK);
            check("i_rd_strobe", val_t'(bus.ram_read_op), val_t'(1));
            check("i_wr_strobe", val_t'(bus.ram_write_op), '0);
            check("i_ram_addr", val_t'(bus.ram_addr), val_t'(addr));
            check("i_ack_early", val_t'(bus.i_ack), '0);
        end
        @(negedge CLK);
        check("i_ack", val_t'(bus.i_ack), val_t'(1));
        check("i_ack_d_quiet", val_t'(bus.d_ack), '0);
        check("i_strobe_off", val_t'(bus.ram_read_op), '0);
        check("i_rdata", bus.i_rdata, exp_rd);
        bus.i_req = 1'b0;
        @(negedge CLK);
        check("i_ack_pulse", val_t'(bus.i_ack), '0);
    endtask

    task automatic do_d(input logic we, input logic [AW-1:0] addr, input val_t wdata, input val_t exp_rd);
        bus.d_req   = 1'b1;
        bus.d_we    = we;
        bus.d_addr  = addr;
        bus.d_wdata = wdata;
        for (int k = 0; k < LAT; k++) begin
            @(negedge CLK);
            check("d_rd_strobe", val_t'(bus.ram_read_op), val_t'(!we));
            check("d_wr_strobe", val_t'(bus.ram_write_op), val_t'(we));
            check("d_ram_addr", val_t'(bus.ram_addr), val_t'(addr));
            if (we) check("d_ram_wdata", bus.ram_data_o, wdata);
            check("d_ack_early", val_t'(bus.d_ack), '0);
        end
        @(negedge CLK);
        check("d_ack", val_t'(bus.d_ack), val_t'(1));
        check("d_ack_i_quiet", val_t'(bus.i_ack), '0);
        check("d_strobes_off", val_t'({bus.ram_read_op, bus.ram_write_op}), '0);
        check("d_rdata", bus.d_rdata, exp_rd);
        bus.d_req = 1'b0;
        @(negedge CLK);
        check("d_ack_pulse", val_t'(bus.d_ack), '0);
    endtask

    task automatic pulse_reset();
        RST = 1'b1;
        repeat (2) @(negedge CLK);
        RST = 1'b0;
    endtask

    initial begin
        val_t a5;
        a5 = {32{8'hA5}};
        RST = 1'b1;
        bus.i_req = 1'b0; bus.i_addr = '0;
        bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = '0; bus.d_wdata = '0;

        // Reset values
        repeat (3) @(negedge CLK);
        check("rst_read_op", val_t'(bus.ram_read_op), '0);
        check("rst_write_op", val_t'(bus.ram_write_op), '0);
        check("rst_ram_addr", val_t'(bus.ram_addr), '0);
        check("rst_ram_data_o", bus.ram_data_o, '0);
        check("rst_acks", val_t'({bus.i_ack, bus.d_ack}), '0);
        check("rst_i_rdata", bus.i_rdata, '0);
        check("rst_d_rdata", bus.d_rdata, '0);
        check("rst_state", val_t'(dbg_state), '0);
`ifdef MEM_ARB_STATS_EN
        check("rst_stats", val_t'({stat_i_grants, stat_d_grants, stat_wait_cycles}), '0);
`endif
        RST = 1'b0;

        // Single I read, D write, D read-back
        do_i_read(32'h40, line_of(8'h40));
        do_d(1'b1, 32'h80, a5, '0);
        do_d(1'b0, 32'h80, '0, a5);
        check("i_rdata_kept", bus.i_rdata, line_of(8'h40));

        // Simultaneous requests after reset: D first, then I
        pulse_reset();
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h40;
        bus.i_req = 1'b1; bus.i_addr = 32'hC0;
        for (int k = 0; k < LAT; k++) begin
            @(negedge CLK);
            check("sim_d_strobe", val_t'(bus.ram_read_op), val_t'(1));
            check("sim_d_addr", val_t'(bus.ram_addr), val_t'(32'h40));
            check("sim_no_ack", val_t'({bus.i_ack, bus.d_ack}), '0);
        end
        @(negedge CLK);
        check("sim_d_ack", val_t'({bus.i_ack, bus.d_ack}), val_t'(2'b01));
        check("sim_d_rdata", bus.d_rdata, line_of(8'h40));
        bus.d_req = 1'b0;
        @(negedge CLK);
        check("sim_gap_idle", val_t'(bus.ram_read_op), '0);
        check("sim_gap_acks", val_t'({bus.i_ack, bus.d_ack}), '0);
        for (int k = 0; k < LAT; k++) begin
            @(negedge CLK);
            check("sim_i_strobe", val_t'(bus.ram_read_op), val_t'(1));
            check("sim_i_addr", val_t'(bus.ram_addr), val_t'(32'hC0));
            check("sim_no_ack2", val_t'({bus.i_ack, bus.d_ack}), '0);
        end
        @(negedge CLK);
        check("sim_i_ack", val_t'({bus.i_ack, bus.d_ack}), val_t'(2'b10));
        check("sim_i_rdata", bus.i_rdata, line_of(8'hC0));
        bus.i_req = 1'b0;
        @(negedge CLK);
`ifdef MEM_ARB_STATS_EN
        check("stat_i_grants", val_t'(stat_i_grants), val_t'(1));
        check("stat_d_grants", val_t'(stat_d_grants), val_t'(1));
        check("stat_wait", val_t'(stat_wait_cycles), val_t'(LAT + 2));
`endif

        // Both requesters keep re-requesting: D, I, D, I
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h20;
        bus.i_req = 1'b1; bus.i_addr = 32'h30;
        for (int t = 0; t < 4; t++) begin
            logic w_d;
            w_d = (t % 2 == 0);
            for (int k = 0; k < LAT; k++) begin
                @(negedge CLK);
                check("rr_strobe", val_t'(bus.ram_read_op), val_t'(1));
                check("rr_addr", val_t'(bus.ram_addr), w_d ? val_t'(32'h20) : val_t'(32'h30));
            end
            @(negedge CLK);
            check("rr_acks", val_t'({bus.i_ack, bus.d_ack}), w_d ? val_t'(2'b01) : val_t'(2'b10));
            if (w_d) begin
                check("rr_d_rdata", bus.d_rdata, line_of(8'h20));
                bus.d_req = 1'b0;
            end else begin
                check("rr_i_rdata", bus.i_rdata, line_of(8'h30));
                bus.i_req = 1'b0;
            end
            @(negedge CLK);
            check("rr_idle", val_t'(bus.ram_read_op), '0);
            if (t < 2) begin
                if (w_d) bus.d_req = 1'b1;
                else     bus.i_req = 1'b1;
            end
        end

        // Reset during the second ACCESS cycle of an I read
        bus.i_req = 1'b1; bus.i_addr = 32'h40;
        @(negedge CLK);
        check("abort_strobe_on", val_t'(bus.ram_read_op), val_t'(1));
        @(negedge CLK);
        RST = 1'b1;
        bus.i_req = 1'b0;
        #1;
        check("abort_strobe_drop", val_t'(bus.ram_read_op), '0);
        check("abort_state", val_t'(dbg_state), '0);
        @(negedge CLK);
        RST = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge CLK);
            check("abort_no_ack", val_t'({bus.i_ack, bus.d_ack}), '0);
            check("abort_no_strobe", val_t'(bus.ram_read_op), '0);
        end
        do_i_read(32'h40, line_of(8'h40));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mem_line_arbiter.md
Name: mem_line_arbiter

Overview:
- Shares the single 256-bit-line data RAM port between two requesters: instruction-line refill (read-only, "I") and data-line refill/writeback (read/write, "D").
- Sits between the core's cache-miss logic and data_ram.
- Sequences each access: drives the RAM read/write strobes for a fixed number of cycles, captures read data, and returns a one-cycle ack to the winner.
- Arbitration is round-robin.

Parameters:
- ADDR_W, 32, address width passed unchanged to RAM.
- LINE_W, 256, line data width.
- RAM_LAT, 2, cycles the RAM op is held before read data is valid; legal range 1..15.

Ports:
- CLK  in  1  clock; all state updates on rising edge.
- RST  in  1  asynchronous active-high reset.
- i_req  in  1  I requests a line read; held until i_ack.
- i_addr  in  ADDR_W  I line address; stable while i_req.
- i_ack  out  1  one-cycle pulse; i_rdata valid in the same cycle.
- i_rdata  out  LINE_W  line returned to I.
- d_req  in  1  D request; held until d_ack.
- d_we  in  1  1 = write line, 0 = read line; stable while d_req.
- d_addr  in  ADDR_W  D line address.
- d_wdata  in  LINE_W  D write line.
- d_ack  out  1  one-cycle pulse; d_rdata valid in same cycle for reads.
- d_rdata  out  LINE_W  line returned to D.
- ram_read_op  out  1  RAM read strobe.
- ram_write_op  out  1  RAM write strobe (RAM writes on every CLK edge while high).
- ram_addr  out  ADDR_W  RAM address.
- ram_data_o  out  LINE_W  write data to RAM.
- ram_data_i  in  LINE_W  read data from RAM.

Behaviour:
- Reset values: all outputs registered. Under RST: ram_read_op=0, ram_write_op=0, ram_addr=0, ram_data_o=0, i_ack=0, d_ack=0, i_rdata=0, d_rdata=0. State=IDLE, cnt=0, last_grant=I.
- Reset mid-operation: strobes and acks drop immediately (asynchronous). The in-flight access is abandoned; no ack is ever issued for it. Requesters re-request after reset.
- States: IDLE, ACCESS, RESP.
- IDLE transitions:
  - No request: stay in IDLE.
  - Only one request: grant it.
  - Both request: grant the requester that is not last_grant.
  - On grant: register addr/we/wdata onto the ram_* outputs, set the strobe for the request type, load cnt=RAM_LAT-1, update last_grant, go to ACCESS.
- ACCESS:
  - Strobe and address held constant.
  - While cnt!=0: cnt decrements.
  - When cnt==0:
    - Read: capture ram_data_i into the winner's rdata register.
    - Clear the strobe.
    - Assert the winner's ack.
    - Go to RESP.
  - A request arriving from the other side during ACCESS waits; it is not preempted.
- RESP:
  - Ack is high for exactly this cycle.
  - Rdata is held after RESP until the next capture for that same requester.
  - Next state is IDLE unconditionally, so there is a minimum of 1 idle cycle between accesses.
- Latency: request seen in IDLE cycle T → strobe high in cycles T+1..T+RAM_LAT → ack in cycle T+RAM_LAT+1.
- Writes: d_ack pulses in the same position. d_rdata is unchanged on writes.
- i_ack and d_ack are never high together. ram_read_op and ram_write_op are never high together.
- Request dropped before ack: protocol violation; the access completes and the ack is still pulsed.
- Requester must deassert req in the cycle after ack, or it is treated as a new request.

Optional Feature:
- Macro: MEM_ARB_STATS_EN.
- Defined: adds outputs stat_i_grants[31:0], stat_d_grants[31:0] and stat_wait_cycles[31:0].
  - Grant counters increment on each grant.
  - stat_wait_cycles increments every cycle in which a requester has req high but is not the current or just-issued grant.
  - All counters reset to 0 and wrap modulo 2^32.
- Undefined: these ports and their counters do not exist; all other behaviour is identical.

Test Plan:
- Reset, then i_req with i_addr=0x40 (RAM_LAT=2): ram_read_op high for 2 cycles with ram_addr=0x40, then i_ack pulses 1 cycle later with i_rdata equal to the RAM line at 0x40.
- d_req with d_we=1, d_addr=0x80, d_wdata=all 0xA5: ram_write_op high for 2 cycles, then d_ack; a subsequent D read of 0x80 returns all 0xA5 and i_rdata is unchanged.
- i_req and d_req asserted in the same cycle after reset: D is served first, then I; the I grant starts exactly one cycle after d_ack's RESP cycle, and the two acks are never concurrent.
- Both requesters hold requests back-to-back for 4 transactions: grants alternate D,I,D,I.
- RST asserted in the second ACCESS cycle of a read: the strobe drops the same cycle and no ack is issued; after release, a new i_req completes normally.
- With MEM_ARB_STATS_EN defined, run the simultaneous-request test: stat_i_grants=1, stat_d_grants=1, stat_wait_cycles=RAM_LAT+2=4.
